ext_wb_bridge: RTL and testbench

- Downstream neighbour of the core top: converts the core's external memory interface (ext_valid/ext_ready, shared by fetch and load/store) into a classic Wishbone B4 master cycle towards user-area memory and peripherals.
- Holds exactly one outstanding transaction.
- Registers all Wishbone outputs.
- Returns completion and read data to the core one cycle after the slave acknowledges.
- Enforces a bus timeout.

---
 rtl/core_bus_pkg.sv | 17 +
 rtl/bus_timeout_counter.sv | 29 ++
 rtl/ext_wb_bridge.sv | 106 ++++++++++
 tb/tb_ext_wb_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core's external bus and its Wishbone bridge.
package core_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  localparam logic [3:0]  WB_SEL_ALL       = 4'b1111;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting on the bus and flags the last permitted one.
// Latency: expired is combinational from the registered count.
// Backpressure: none; saturates instead of wrapping, TIMEOUT_CYCLES=0 never expires.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/ext_wb_bridge.sv
// Core external-memory request to Wishbone B4 classic master, one transaction in flight.
// Latency: cyc one cycle after ext_valid, ext_ready one cycle after ack/err/timeout.
// Backpressure: ext_valid is only sampled in IDLE; the core holds its request until ext_ready.
module ext_wb_bridge
  import core_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_valid,
  input  logic        ext_instruction,
  output logic        ext_ready,
  input  logic [31:0] ext_address,
  input  logic [31:0] ext_write_data,
  input  logic [3:0]  ext_write_strobe,
  output logic [31:0] ext_read_data,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic        wbm_tga_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        bus_error,
  output logic [31:0] bus_error_address
);

  bus_state_t  state;
  logic [31:0] req_addr;
  logic        tmo_expired;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != WAIT),
    .enable  (state == WAIT),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      req_addr          <= '0;
      ext_ready         <= 1'b0;
      ext_read_data     <= '0;
      wbm_cyc_o         <= 1'b0;
      wbm_stb_o         <= 1'b0;
      wbm_we_o          <= 1'b0;
      wbm_sel_o         <= '0;
      wbm_adr_o         <= '0;
      wbm_dat_o         <= '0;
      wbm_tga_o         <= 1'b0;
      bus_error         <= 1'b0;
      bus_error_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ext_valid) begin
            req_addr  <= ext_address;
            wbm_adr_o <= word_align(ext_address);
            wbm_we_o  <= |ext_write_strobe;
            wbm_sel_o <= (|ext_write_strobe) ? ext_write_strobe : WB_SEL_ALL;
            wbm_dat_o <= ext_write_data;
            wbm_tga_o <= ext_instruction;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // err beats ack, and ack beats the timeout on the same cycle
          if (wbm_err_i || wbm_ack_i || tmo_expired) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            ext_ready <= 1'b1;
            state     <= RESP;
            if (wbm_err_i || !wbm_ack_i) begin
              bus_error         <= 1'b1;
              bus_error_address <= req_addr;
              ext_read_data     <= wbm_we_o ? '0 : ERR_DATA;
            end else begin
              ext_read_data     <= wbm_we_o ? '0 : wbm_dat_i;
            end
          end
        end
        RESP: begin
          ext_ready     <= 1'b0;
          ext_read_data <= '0;
          bus_error     <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_wb_bridge.sv
// Directed bench for ext_wb_bridge with a transaction-level reference model checked every cycle.
module tb_ext_wb_bridge;

  localparam int          TO      = 8;
  localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ext_valid = 1'b0;
  logic        ext_instruction = 1'b0;
  logic        ext_ready;
  logic [31:0] ext_address = '0;
  logic [31:0] ext_write_data = '0;
  logic [3:0]  ext_write_strobe = '0;
  logic [31:0] ext_read_data;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_tga_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        bus_error;
  logic [31:0] bus_error_address;

  int n_cmp = 0;
  int n_bad = 0;

  ext_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .ext_valid         (ext_valid),
    .ext_instruction   (ext_instruction),
    .ext_ready         (ext_ready),
    .ext_address       (ext_address),
    .ext_write_data    (ext_write_data),
    .ext_write_strobe  (ext_write_strobe),
    .ext_read_data     (ext_read_data),
    .wbm_cyc_o         (wbm_cyc_o),
    .wbm_stb_o         (wbm_stb_o),
    .wbm_we_o          (wbm_we_o),
    .wbm_sel_o         (wbm_sel_o),
    .wbm_adr_o         (wbm_adr_o),
    .wbm_dat_o         (wbm_dat_o),
    .wbm_tga_o         (wbm_tga_o),
    .wbm_dat_i         (wbm_dat_i),
    .wbm_ack_i         (wbm_ack_i),
    .wbm_err_i         (wbm_err_i),
    .bus_error         (bus_error),
    .bus_error_address (bus_error_address)
  );

  always #5 clk = ~clk;

  // Reference model: one bus transaction at a time, tracked by how many bus cycles it has lasted.
  bit          m_started = 1'b0;
  bit          m_active = 1'b0;
  bit          m_reply = 1'b0;
  bit          m_fresh = 1'b1;
  bit          m_failed = 1'b0;
  int          m_elapsed = 0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_err_addr = '0;
  logic [31:0] t_addr = '0, t_wdata = '0;
  logic [3:0]  t_strb = '0;
  bit          t_instr = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_started  = 1'b1;
      m_active   = 1'b0;
      m_reply    = 1'b0;
      m_fresh    = 1'b1;
      m_err_addr = '0;
    end else if (m_reply) begin
      m_reply = 1'b0;
    end else if (m_active) begin
      m_elapsed++;
      if (wbm_err_i || wbm_ack_i || (TO != 0 && m_elapsed == TO)) begin
        m_active = 1'b0;
        m_reply  = 1'b1;
        m_failed = wbm_err_i || !wbm_ack_i;
        if (t_strb != 4'h0)  m_rdata = 32'h0;
        else if (m_failed)   m_rdata = ERR_VAL;
        else                 m_rdata = wbm_dat_i;
        if (m_failed) m_err_addr = t_addr;
      end
    end else if (ext_valid) begin
      t_addr    = ext_address;
      t_wdata   = ext_write_data;
      t_strb    = ext_write_strobe;
      t_instr   = ext_instruction;
      m_active  = 1'b1;
      m_fresh   = 1'b0;
      m_elapsed = 0;
    end
  end

  logic [72:0] exp_ctl, act_ctl;
  logic [64:0] exp_req, act_req;

  always @(negedge clk) begin
    if (m_started) begin
      exp_ctl = {m_active, m_active, m_active && (t_strb != 4'h0),
                 m_active ? ((t_strb != 4'h0) ? t_strb : 4'hF) : 4'h0,
                 m_reply, m_reply ? m_rdata : 32'h0, m_reply && m_failed, m_err_addr};
      act_ctl = {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, ext_ready, ext_read_data,
                 bus_error, bus_error_address};
      n_cmp++;
      if (act_ctl !== exp_ctl) begin
        n_bad++;
        $display("FAIL model_ctl t=%0t got %h want %h", $time, act_ctl, exp_ctl);
      end
      if (m_active || m_fresh) begin
        exp_req = m_active ? {t_addr & 32'hFFFF_FFFC, t_wdata, t_instr} : 65'h0;
        act_req = {wbm_adr_o, wbm_dat_o, wbm_tga_o};
        n_cmp++;
        if (act_req !== exp_req) begin
          n_bad++;
          $display("FAIL model_req t=%0t got %h want %h", $time, act_req, exp_req);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ack_at: index of the bus cycle carrying ack (-1 = silent slave)
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                        input bit instr, input int ack_at, input bit with_err, input bit scramble,
                        input logic [31:0] slave_dat, input int exp_lat, input logic [31:0] exp_rd,
                        input bit exp_berr, input logic [31:0] exp_adr, input logic [3:0] exp_sel);
    int lat;
    bit got;
    ext_address      = addr;
    ext_write_data   = wdata;
    ext_write_strobe = strb;
    ext_instruction  = instr;
    ext_valid        = 1'b1;
    tick();
    check_lit("cyc_start", {31'h0, wbm_cyc_o}, 32'h1);
    check_lit("adr", wbm_adr_o, exp_adr);
    check_lit("sel", {28'h0, wbm_sel_o}, {28'h0, exp_sel});
    if (scramble) begin
      ext_address      = ~addr;
      ext_write_data   = ~wdata;
      ext_write_strobe = ~strb;
    end
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      wbm_dat_i = slave_dat;
      wbm_ack_i = (i == ack_at);
      wbm_err_i = with_err && (i == ack_at);
      tick();
      lat++;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (ext_ready) got = 1'b1;
    end
    check_lit("latency", lat, exp_lat);
    check_lit("rdata", ext_read_data, exp_rd);
    check_lit("bus_error", {31'h0, bus_error}, {31'h0, exp_berr});
    if (exp_berr) check_lit("err_addr", bus_error_address, addr);
    ext_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    check_lit("rst_ready", {31'h0, ext_ready}, 32'h0);
    check_lit("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
    check_lit("rst_err_addr", bus_error_address, 32'h0);
    reset = 1'b0;
    tick();

    // read acked in first bus cycle
    do_txn(32'h3000_0006, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF,
           2, 32'hDEAD_BEEF, 1'b0, 32'h3000_0004, 4'hF);
    tick();
    // write acked after 5 wait cycles, request fields disturbed mid-cycle
    do_txn(32'h3000_0010, 32'h1234_5678, 4'b0011, 1'b0, 5, 1'b0, 1'b1, 32'hAAAA_AAAA,
           7, 32'h0, 1'b0, 32'h3000_0010, 4'b0011);
    tick();
    // err and ack together
    do_txn(32'h3000_0103, 32'h0, 4'h0, 1'b0, 0, 1'b1, 1'b0, 32'h1111_1111,
           2, 32'hFFFF_FFFF, 1'b1, 32'h3000_0100, 4'hF);
    tick();
    // silent slave: timeout
    do_txn(32'h2000_0008, 32'h0, 4'h0, 1'b0, -1, 1'b0, 1'b0, 32'h0,
           TO + 1, 32'hFFFF_FFFF, 1'b1, 32'h2000_0008, 4'hF);
    tick();
    // ack on the last permitted cycle wins
    do_txn(32'h2000_000C, 32'h0, 4'h0, 1'b0, TO - 1, 1'b0, 1'b0, 32'hCAFE_F00D,
           TO + 1, 32'hCAFE_F00D, 1'b0, 32'h2000_000C, 4'hF);
    check_lit("err_addr_kept", bus_error_address, 32'h2000_0008);
    tick();
    // timed-out write returns zero data
    do_txn(32'h1000_0004, 32'h0BAD_0BAD, 4'hF, 1'b0, -1, 1'b0, 1'b0, 32'h0,
           TO + 1, 32'h0, 1'b1, 32'h1000_0004, 4'hF);

    // stray ack/err while idle
    tick();
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    repeat (2) tick();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    tick();
    check_lit("stray_ready", {31'h0, ext_ready}, 32'h0);
    check_lit("stray_err", {31'h0, bus_error}, 32'h0);

    // back-to-back: fetch then load with ext_valid held
    ext_instruction  = 1'b1;
    ext_address      = 32'h0000_0100;
    ext_write_strobe = 4'h0;
    ext_valid        = 1'b1;
    tick();
    check_lit("b2b_tga", {31'h0, wbm_tga_o}, 32'h1);
    wbm_dat_i = 32'h0000_0013;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    check_lit("b2b_ready1", {31'h0, ext_ready}, 32'h1);
    check_lit("b2b_rdata1", ext_read_data, 32'h0000_0013);
    ext_instruction = 1'b0;
    ext_address     = 32'h3000_0020;
    tick();
    check_lit("b2b_gap", {31'h0, wbm_cyc_o}, 32'h0);
    tick();
    check_lit("b2b_cyc2", {31'h0, wbm_cyc_o}, 32'h1);
    check_lit("b2b_tga2", {31'h0, wbm_tga_o}, 32'h0);
    check_lit("b2b_adr2", wbm_adr_o, 32'h3000_0020);
    wbm_dat_i = 32'h55AA_55AA;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    ext_valid = 1'b0;
    check_lit("b2b_rdata2", ext_read_data, 32'h55AA_55AA);
    repeat (3) tick();
    check_lit("b2b_no_dup", {31'h0, wbm_cyc_o}, 32'h0);

    // reset while waiting
    ext_address = 32'h3000_0040;
    ext_valid   = 1'b1;
    repeat (2) tick();
    check_lit("rw_cyc", {31'h0, wbm_cyc_o}, 32'h1);
    reset     = 1'b1;
    ext_valid = 1'b0;
    tick();
    check_lit("rw_wb", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_tga_o, wbm_sel_o, 24'h0}, 32'h0);
    check_lit("rw_adr", wbm_adr_o, 32'h0);
    reset = 1'b0;
    repeat (3) tick();
    check_lit("rw_ready", {31'h0, ext_ready}, 32'h0);
    do_txn(32'h0000_0204, 32'h0, 4'h0, 1'b1, 2, 1'b0, 1'b0, 32'h0040_0093,
           4, 32'h0040_0093, 1'b0, 32'h0000_0204, 4'hF);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
